// File: rtl/instr_fetch_pkg.sv
// Shared instruction package: opcode encodings, fetch constants and the
// fetch FSM state type used by instr_fetch and pc_counter.
package instr_fetch_pkg;

    localparam int IR_W  = 16;
    localparam int PC_W  = 8;
    localparam int TMO_W = 4;

    // Opcode field lives in IR[15:12]
    localparam logic [3:0] OPC_ADD  = 4'h1;
    localparam logic [3:0] OPC_SUB  = 4'h2;
    localparam logic [3:0] OPC_LD   = 4'h3;
    localparam logic [3:0] OPC_ST   = 4'h4;
    localparam logic [3:0] OPC_JMP  = 4'h5;
    localparam logic [3:0] OPC_NOOP = 4'hF;

    // Full no-operation instruction word substituted on a fetch timeout
    localparam logic [IR_W-1:0] P_NOOP = {OPC_NOOP, 12'h000};

    // Number of WAIT cycles tolerated before a fetch is declared lost
    localparam logic [TMO_W-1:0] FETCH_TIMEOUT = 4'd15;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_t;

    function automatic logic [3:0] opcode_of(input logic [IR_W-1:0] instr);
        return instr[IR_W-1:IR_W-4];
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter with clear, increment and a pending-increment bit that
// defers increments requested during an outstanding fetch so the memory
// address stays stable until the fetch completes.
module pc_counter
    import instr_fetch_pkg::*;
(
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            clr,
    input  logic            inc,
    input  logic            hold,
    input  logic            apply,
    output logic [PC_W-1:0] pc
);

    logic pend;

    // PC update: clear wins, direct increment when idle, deferred when holding
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pc   <= '0;
            pend <= 1'b0;
        end else if (clr) begin
            pc   <= '0;
            pend <= 1'b0;
        end else if (!hold) begin
            if (inc) begin
                pc <= pc + PC_W'(1);
            end
            pend <= 1'b0;
        end else if (apply) begin
            // Any number of increment requests during a fetch collapse to one
            if (pend || inc) begin
                pc <= pc + PC_W'(1);
            end
            pend <= 1'b0;
        end else if (inc) begin
            pend <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: two-state fetch FSM driving the instruction memory
// handshake, the instruction register, and the pc_counter sub-module.
// Optional build macro FETCH_TIMEOUT_EN adds a WAIT-cycle watchdog that
// substitutes P_NOOP and raises a sticky FETCH_ERR when memory never acks.
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            PC_CLR,
    input  logic            PC_IC,
    input  logic            IR_LD,
    output logic [PC_W-1:0] IM_ADDR,
    output logic            IM_REQ,
    input  logic            IM_ACK,
    input  logic [IR_W-1:0] IM_DATA,
    output logic [IR_W-1:0] IR,
    output logic            IR_VALID,
    output logic            BUSY,
    output logic [PC_W-1:0] PC,
    output logic            FETCH_ERR
);

    fetch_state_t state, state_nxt;
    logic         in_wait;
    logic         fetch_start;
    logic         fetch_done;
    logic         timeout_hit;

    assign in_wait     = (state == S_WAIT);
    assign fetch_start = (state == S_IDLE) && IR_LD && !PC_CLR;
    assign fetch_done  = in_wait && IM_ACK && !PC_CLR;

`ifdef FETCH_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             fetch_err_q;

    // Fires on the FETCH_TIMEOUT-th WAIT edge without an acknowledge
    assign timeout_hit = in_wait && !IM_ACK && !PC_CLR &&
                         (tmo_cnt == FETCH_TIMEOUT - 4'd1);

    // Count WAIT cycles, restarting on every fetch entry
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            tmo_cnt <= '0;
        end else if (fetch_start) begin
            tmo_cnt <= '0;
        end else if (in_wait) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Sticky error flag, cleared only by PC_CLR or reset
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            fetch_err_q <= 1'b0;
        end else if (PC_CLR) begin
            fetch_err_q <= 1'b0;
        end else if (timeout_hit) begin
            fetch_err_q <= 1'b1;
        end
    end

    assign FETCH_ERR = fetch_err_q;
`else
    assign timeout_hit = 1'b0;
    assign FETCH_ERR   = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs, decoded from registered state only
    always_comb begin
        state_nxt = state;
        IM_REQ    = 1'b0;
        BUSY      = 1'b0;
        case (state)
            S_IDLE: begin
                if (fetch_start) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                IM_REQ = 1'b1;
                BUSY   = 1'b1;
                if (PC_CLR || IM_ACK || timeout_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Instruction register and its valid flag
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            IR       <= '0;
            IR_VALID <= 1'b0;
        end else if (PC_CLR) begin
            IR_VALID <= 1'b0;
        end else if (fetch_start) begin
            IR_VALID <= 1'b0;
        end else if (fetch_done) begin
            IR       <= IM_DATA;
            IR_VALID <= 1'b1;
        end else if (timeout_hit) begin
            IR       <= P_NOOP;
            IR_VALID <= 1'b1;
        end
    end

    pc_counter u_pc_counter (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .clr     (PC_CLR),
        .inc     (PC_IC),
        .hold    (in_wait),
        .apply   (fetch_done || timeout_hit),
        .pc      (PC)
    );

    assign IM_ADDR = PC;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Clock  in  1  sole clock; all state updates on its rising edge.
REQ-002 Reset_n  in  1  asynchronous, active-low reset.
REQ-003 PC_CLR  in  1  program counter clear command from control unit.
REQ-004 PC_IC  in  1  program counter increment command from control unit.
REQ-005 IR_LD  in  1  fetch request: read the instruction at PC and load the IR.
REQ-006 IM_ADDR  out  8  instruction memory address; equals PC.
REQ-007 IM_REQ  out  1  instruction memory read request.
REQ-008 IM_ACK  in  1  instruction memory data-valid acknowledge.
REQ-009 IM_DATA  in  16  instruction memory read data.
REQ-010 IR  out  16  instruction register; feeds control unit decode.
REQ-011 IR_VALID  out  1  IR holds a completed fetch.
REQ-012 BUSY  out  1  fetch outstanding; control unit shall stall while high.
REQ-013 PC  out  8  current program counter.
REQ-014 FETCH_ERR  out  1  sticky fetch-timeout flag.

Function
REQ-015 The FSM SHALL have states IDLE and WAIT; with timeout compiled in, no further state is added.
REQ-016 IDLE + IR_LD=1 + PC_CLR=0 at an edge SHALL go to WAIT and clear IR_VALID.
REQ-017 In WAIT, IM_REQ=1 and BUSY=1; in IDLE, IM_REQ=0 and BUSY=0; both decode from registered state only.
REQ-018 IM_ADDR SHALL equal PC and stay stable from entering WAIT until the ACK edge.
REQ-019 WAIT + IM_ACK=1 at an edge SHALL load IR<=IM_DATA, set IR_VALID=1, and return to IDLE; minimum fetch latency is 2 edges (IR_LD edge, ACK edge).
REQ-020 IM_ACK while in IDLE SHALL be ignored; IR_LD while in WAIT SHALL be ignored.
REQ-021 PC_CLR=1 SHALL set PC=0x00 at the edge in any state, abort an outstanding fetch (go to IDLE), clear IR_VALID, and clear FETCH_ERR.
REQ-022 PC_CLR has priority over PC_IC, IR_LD and IM_ACK in the same cycle.
REQ-023 PC_IC=1 in IDLE SHALL increment PC by 1 modulo 256 (0xFF wraps to 0x00).
REQ-024 PC_IC=1 in WAIT SHALL set a pending bit applied on the ACK or timeout edge, keeping IM_ADDR stable; multiple PC_IC pulses in one WAIT SHALL increment once only.
REQ-025 IR holds its value between fetches; IR_VALID stays 1 until the next fetch starts or PC_CLR.

Reset
REQ-026 Reset_n=0 SHALL immediately force state=IDLE, PC=0x00, IR=0x0000, IR_VALID=0, FETCH_ERR=0, the pending-increment bit=0, and the timeout counter=0.
REQ-027 Reset assertion during WAIT SHALL abandon the fetch; IM_REQ falls without waiting for a clock edge.

Configuration
REQ-028 With macro FETCH_TIMEOUT_EN defined, a 4-bit counter SHALL count WAIT cycles; the counter resets on entry to WAIT.
REQ-029 When the counter reaches FETCH_TIMEOUT (15) with no ACK, the block SHALL:
 - load IR<=P_NOOP encoding and set IR_VALID=1;
 - set FETCH_ERR=1 (sticky);
 - apply any pending increment and return to IDLE.
REQ-030 Without FETCH_TIMEOUT_EN, WAIT SHALL persist until ACK or PC_CLR, and FETCH_ERR SHALL be tied to 0.

Structure
REQ-031 The opcode constants (including P_NOOP), the FETCH_TIMEOUT value, and the FSM state enum SHALL live in the shared instruction package alongside the existing opcode definitions.
REQ-032 The PC register with clear/increment/pending logic SHALL be a sub-module named pc_counter; the FSM and IR stay in instr_fetch.

Verification
REQ-033 Reset, then IR_LD pulse with PC=0x00, then IM_ACK one cycle later with IM_DATA=0x1234: IR=0x1234, IR_VALID=1, BUSY=0.
REQ-034 Fetch at PC=0x05 with ACK delayed 6 cycles, and PC_IC pulsed twice during WAIT: IM_ADDR stays 0x05 throughout; PC=0x06 after ACK.
REQ-035 PC=0xFF, then PC_IC in IDLE: PC=0x00.
REQ-036 PC_CLR, PC_IC and IM_ACK asserted together in WAIT at PC=0x10: PC=0x00, state IDLE, IR_VALID=0, IR unchanged.
REQ-037 FETCH_TIMEOUT_EN defined, no ACK for 15 cycles: IR=P_NOOP, IR_VALID=1, FETCH_ERR=1; a subsequent PC_CLR clears FETCH_ERR.
REQ-038 Reset_n asserted mid-WAIT between clock edges: IM_REQ=0, PC=0x00, IR=0x0000 before the next edge.
